// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: start bit, DATA_BITS data bits LSB-first, optional parity, STOP_BITS stop bits.
// Optional parity bit compiled in with macro UART_TX_PARITY_EN.
`timescale 1ns/1ps
module uart_tx_ctrl #(
    parameter int unsigned CLK_DIV    = 868,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic       tx_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BIT_W = 3;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_d, busy_d, ready_d, done_d;
    logic             bit_end;
`ifdef UART_TX_PARITY_EN
    logic             par_q, par_d;
`endif

    // Next-state logic; outputs are derived from the next state so they register cleanly.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        bit_end = (cnt_q == CNT_LAST);

        if (state_q != IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (tx_valid_i && tx_ready_o) begin
                    shift_d = tx_data_i;
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = START;
`ifdef UART_TX_PARITY_EN
                    par_d   = (PARITY_ODD != 0);
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
`ifdef UART_TX_PARITY_EN
                    par_d   = par_q ^ shift_q[0];
`endif
                    if (bit_q == DATA_LAST) begin
                        bit_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    if (bit_q == STOP_LAST) begin
                        bit_d   = '0;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = par_d;
`endif
            default: tx_d = 1'b1;
        endcase
        busy_d  = (state_d != IDLE);
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            tx_o       <= 1'b1;
            tx_ready_o <= 1'b1;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tx_o       <= tx_d;
            tx_ready_o <= ready_d;
            busy_o     <= busy_d;
            done_o     <= done_d;
`ifdef UART_TX_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

endmodule
